// File: rtl/ap_pkg.sv
// ap_pkg: shared definitions for the associative-processor tag stage.
//   ap_state_e    : tag-unit FSM states
//   PASS_*        : lookup-table pass codes driven to the cell_C columns
//   cnt_w / idx_w : width helpers for population counts and row indices
package ap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    WRITE,
    CNT,
    DONE
  } ap_state_e;

  localparam logic [2:0] PASS_NONE = 3'd0;
  localparam logic [2:0] PASS_1    = 3'd1;
  localparam logic [2:0] PASS_2    = 3'd2;
  localparam logic [2:0] PASS_3    = 3'd3;
  localparam logic [2:0] PASS_4    = 3'd4;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n items; never below 1 so ports stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ap_chunk_reduce.sv
// ap_chunk_reduce: combinational reduction of one CHUNK-bit slice of the tag.
//   bits_i : slice of the tag
//   cnt_o  : number of set bits
//   idx_o  : lowest set bit position (0 when none set)
//   vld_o  : at least one bit set
module ap_chunk_reduce
  import ap_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0]        bits_i,
  output logic [cnt_w(CHUNK)-1:0] cnt_o,
  output logic [idx_w(CHUNK)-1:0] idx_o,
  output logic                    vld_o
);

  localparam int CW = cnt_w(CHUNK);
  localparam int IW = idx_w(CHUNK);

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    cnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (bits_i[i]) begin
        idx_o = IW'(i);
        vld_o = 1'b1;
      end
      cnt_o = cnt_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/ap_tag_unit.sv
// ap_tag_unit: tag stage of the associative processor.
//   clk, rst_In : clock, async active-low reset
//   start       : begin compare/write/count pass (IDLE only); pass_in latched with it
//   tag_set_all : in IDLE, load tag with all-ones
//   tag_cell_in : NUM_COL match vectors, column k at [k*DATA_DEPTH +: DATA_DEPTH]
//   tag         : registered tag back to the columns
//   pass_out    : latched pass code during WRITE, else 0
//   write_en    : high during WRITE
//   busy        : high outside IDLE
//   done        : one-cycle pulse in DONE
//   match_cnt, first_vld, first_idx : reduction results, updated in DONE, held otherwise
module ap_tag_unit
  import ap_pkg::*;
#(
  parameter int DATA_DEPTH = 128,
  parameter int NUM_COL    = 3,
  parameter int CHUNK      = 16
) (
  input  logic                          clk,
  input  logic                          rst_In,
  input  logic                          start,
  input  logic [2:0]                    pass_in,
  input  logic                          tag_set_all,
  input  logic [NUM_COL*DATA_DEPTH-1:0] tag_cell_in,
  output logic [DATA_DEPTH-1:0]         tag,
  output logic [2:0]                    pass_out,
  output logic                          write_en,
  output logic                          busy,
  output logic                          done,
  output logic [cnt_w(DATA_DEPTH)-1:0]  match_cnt,
  output logic                          first_vld,
  output logic [idx_w(DATA_DEPTH)-1:0]  first_idx
);

  localparam int NUM_CHUNK = DATA_DEPTH / CHUNK;
  localparam int CNT_W     = cnt_w(DATA_DEPTH);
  localparam int IDX_W     = idx_w(DATA_DEPTH);
  localparam int CH_W      = idx_w(NUM_CHUNK);
  localparam int CC_W      = cnt_w(CHUNK);
  localparam int CI_W      = idx_w(CHUNK);

  ap_state_e              state_q, state_d;
  logic [DATA_DEPTH-1:0]  tag_q, tag_d;
  logic [2:0]             pass_q, pass_d;
  logic [2:0]             pass_out_q, pass_out_d;
  logic                   write_en_q, write_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CH_W-1:0]        chunk_q, chunk_d;
  logic [CNT_W-1:0]       acc_q, acc_d;
  logic                   fnd_q, fnd_d;
  logic [IDX_W-1:0]       fidx_q, fidx_d;
  logic [CNT_W-1:0]       match_cnt_q, match_cnt_d;
  logic                   first_vld_q, first_vld_d;
  logic [IDX_W-1:0]       first_idx_q, first_idx_d;

  // Column AND: a row is tagged only if every column matched it.
  logic [DATA_DEPTH-1:0] tag_and;
  always_comb begin
    tag_and = '1;
    for (int k = 0; k < NUM_COL; k++)
      tag_and = tag_and & tag_cell_in[k*DATA_DEPTH +: DATA_DEPTH];
  end

  // Single reducer, fed the chunk selected by the counter.
  logic [NUM_CHUNK-1:0][CHUNK-1:0] tag_chunks;
  logic [CC_W-1:0]                 chunk_cnt;
  logic [CI_W-1:0]                 chunk_idx;
  logic                            chunk_vld;

  assign tag_chunks = tag_q;

  ap_chunk_reduce #(.CHUNK(CHUNK)) u_reduce (
    .bits_i (tag_chunks[chunk_q]),
    .cnt_o  (chunk_cnt),
    .idx_o  (chunk_idx),
    .vld_o  (chunk_vld)
  );

  // Running totals including the chunk currently on the reducer.
  logic [CNT_W-1:0] sum_now;
  logic             hit_now;
  logic [IDX_W-1:0] idx_now;
  always_comb begin
    sum_now = acc_q + CNT_W'(chunk_cnt);
    hit_now = fnd_q | chunk_vld;
    idx_now = fnd_q ? fidx_q
                    : IDX_W'(chunk_q) * IDX_W'(CHUNK) + IDX_W'(chunk_idx);
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    pass_d      = pass_q;
    chunk_d     = chunk_q;
    acc_d       = acc_q;
    fnd_d       = fnd_q;
    fidx_d      = fidx_q;
    match_cnt_d = match_cnt_q;
    first_vld_d = first_vld_q;
    first_idx_d = first_idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CMP;
          pass_d  = pass_in;
        end else if (tag_set_all) begin
          tag_d = '1;
        end
      end
      CMP: begin
        tag_d   = tag_and;
        state_d = (pass_q == PASS_NONE) ? CNT : WRITE;
      end
      WRITE: state_d = CNT;
      CNT: begin
        acc_d   = sum_now;
        fnd_d   = hit_now;
        fidx_d  = idx_now;
        chunk_d = chunk_q + 1'b1;
        // Last chunk: publish final totals so they appear alongside done.
        if (chunk_q == CH_W'(NUM_CHUNK - 1)) begin
          state_d     = DONE;
          match_cnt_d = sum_now;
          first_vld_d = hit_now;
          first_idx_d = hit_now ? idx_now : '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Fresh accumulation on every entry to CNT.
    if (state_d == CNT && state_q != CNT) begin
      chunk_d = '0;
      acc_d   = '0;
      fnd_d   = 1'b0;
      fidx_d  = '0;
    end

    // Handshake outputs are registered versions of the next state.
    write_en_d = (state_d == WRITE);
    pass_out_d = (state_d == WRITE) ? pass_d : PASS_NONE;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_In) begin
    if (!rst_In) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      pass_q      <= PASS_NONE;
      pass_out_q  <= PASS_NONE;
      write_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chunk_q     <= '0;
      acc_q       <= '0;
      fnd_q       <= 1'b0;
      fidx_q      <= '0;
      match_cnt_q <= '0;
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      pass_q      <= pass_d;
      pass_out_q  <= pass_out_d;
      write_en_q  <= write_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      chunk_q     <= chunk_d;
      acc_q       <= acc_d;
      fnd_q       <= fnd_d;
      fidx_q      <= fidx_d;
      match_cnt_q <= match_cnt_d;
      first_vld_q <= first_vld_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign tag       = tag_q;
  assign pass_out  = pass_out_q;
  assign write_en  = write_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = match_cnt_q;
  assign first_vld = first_vld_q;
  assign first_idx = first_idx_q;

endmodule

// File: tb/tb_ap_tag_unit.sv
// tb_ap_tag_unit: self-checking bench for ap_tag_unit at default parameters.
// A per-cycle reference model (pass timeline by offset from start, tag as the
// column AND, results by popcount / first-one scan) is compared on every cycle.
module tb_ap_tag_unit;

  localparam int D   = 128;
  localparam int NCH = 8;   // DATA_DEPTH / CHUNK at defaults

  logic           clk;
  logic           rst_In;
  logic           start;
  logic [2:0]     pass_in;
  logic           tag_set_all;
  logic [3*D-1:0] tag_cell_in;
  logic [D-1:0]   tag;
  logic [2:0]     pass_out;
  logic           write_en, busy, done;
  logic [7:0]     match_cnt;
  logic           first_vld;
  logic [6:0]     first_idx;

  ap_tag_unit dut (
    .clk(clk), .rst_In(rst_In), .start(start), .pass_in(pass_in),
    .tag_set_all(tag_set_all), .tag_cell_in(tag_cell_in), .tag(tag),
    .pass_out(pass_out), .write_en(write_en), .busy(busy), .done(done),
    .match_cnt(match_cnt), .first_vld(first_vld), .first_idx(first_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [D-1:0] ONE  = 128'd1;
  localparam logic [D-1:0] ALL1 = {D{1'b1}};

  // ---------------- reference model ----------------
  int           m_off;   // cycles since accepted start (1 = compare cycle), -1 idle
  int           m_len;   // offset at which done is expected
  logic [2:0]   m_pass;
  logic [D-1:0] m_tag;
  int           m_cnt, m_idx;
  bit           m_vld;

  function automatic logic [D-1:0] col_and(input logic [3*D-1:0] v);
    return v[D-1:0] & v[2*D-1:D] & v[3*D-1:2*D];
  endfunction

  function automatic int first_one(input logic [D-1:0] t);
    for (int i = 0; i < D; i++) if (t[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_off = -1; m_len = 0; m_pass = 3'd0; m_tag = '0;
    m_cnt = 0; m_idx = 0; m_vld = 1'b0;
  endtask

  task automatic model_edge();
    if (m_off < 0) begin
      if (start) begin
        m_off  = 1;
        m_pass = pass_in;
        m_len  = (pass_in == 3'd0) ? 2 + NCH : 3 + NCH;
      end else if (tag_set_all) begin
        m_tag = ALL1;
      end
    end else begin
      m_off++;
      if (m_off == 2) m_tag = col_and(tag_cell_in);
      if (m_off == m_len) begin
        m_cnt = $countones(m_tag);
        m_vld = (m_tag != '0);
        m_idx = first_one(m_tag);
      end else if (m_off > m_len) begin
        m_off = -1;
      end
    end
  endtask

  task automatic check(input string name, input logic [D-1:0] got, input logic [D-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit exp_we;
    exp_we = (m_off == 2) && (m_pass != 3'd0);
    check("tag",       tag,                   m_tag);
    check("busy",      D'(busy),              D'(m_off >= 1));
    check("write_en",  D'(write_en),          D'(exp_we));
    check("pass_out",  D'(pass_out),          exp_we ? D'(m_pass) : '0);
    check("done",      D'(done),              D'(m_off == m_len));
    check("match_cnt", D'(match_cnt),         D'(m_cnt));
    check("first_vld", D'(first_vld),         D'(m_vld));
    check("first_idx", D'(first_idx),         D'(m_idx));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_In) model_edge();
    #1;
    compare_all();
  endtask

  task automatic assert_reset();
    rst_In = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  // Run one pass from IDLE; returns the cycle numbers of done / first write_en.
  task automatic run_pass(input logic [2:0] p, input logic [3*D-1:0] cols,
                          output int done_cyc, output int we_cyc);
    int cyc;
    pass_in = p; tag_cell_in = cols; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; done_cyc = 0; we_cyc = 0;
    if (write_en) we_cyc = cyc;
    while (!done && cyc < 25) begin
      tick();
      cyc++;
      if (write_en && we_cyc == 0) we_cyc = cyc;
      if (done) done_cyc = cyc;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]   pass;
    logic [D-1:0] c0, c1, c2;
    int           cnt;
    bit           vld;
    int           idx;
    int           done_cyc;
    int           we_cyc;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] p, input logic [D-1:0] a, b, c,
                              input int cnt, input bit vld, input int idx,
                              input int dc, input int wc);
    vec_t v;
    v.pass = p; v.c0 = a; v.c1 = b; v.c2 = c;
    v.cnt = cnt; v.vld = vld; v.idx = idx; v.done_cyc = dc; v.we_cyc = wc;
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    int dcyc, wcyc, ndone;
    logic [D-1:0] c[3];

    vecs[0] = mk(3'd1, ALL1, ~(ONE << 7), ALL1, 127, 1'b1, 0, 11, 2);
    vecs[1] = mk(3'd0, (ONE << 37) | (ONE << 90) | (ONE << 5),
                 (ONE << 37) | (ONE << 90) | (ONE << 100), ALL1, 2, 1'b1, 37, 10, 0);
    vecs[2] = mk(3'd3, {{64{1'b1}}, {64{1'b0}}}, {{64{1'b0}}, {64{1'b1}}}, ALL1,
                 0, 1'b0, 0, 11, 2);
    vecs[3] = mk(3'd2, ALL1, ALL1, ALL1, 128, 1'b1, 0, 11, 2);
    vecs[4] = mk(3'd4, ONE << 127, ALL1, ALL1, 1, 1'b1, 127, 11, 2);
    vecs[5] = mk(3'd0, (ONE << 15) | (ONE << 16), ALL1, ALL1, 2, 1'b1, 15, 10, 0);

    // Reset state
    start = 1'b0; pass_in = 3'd0; tag_set_all = 1'b0; tag_cell_in = '0;
    assert_reset();
    tick(); tick();
    rst_In = 1'b1;
    tick();

    // tag_set_all in IDLE
    tag_set_all = 1'b1;
    tick();
    tag_set_all = 1'b0;
    check("set_all_tag", tag, ALL1);
    check("set_all_busy", D'(busy), '0);
    tick();

    // Table-driven passes
    foreach (vecs[i]) begin
      run_pass(vecs[i].pass, {vecs[i].c2, vecs[i].c1, vecs[i].c0}, dcyc, wcyc);
      check($sformatf("v%0d_done_cyc", i), D'(dcyc), D'(vecs[i].done_cyc));
      check($sformatf("v%0d_we_cyc", i),   D'(wcyc), D'(vecs[i].we_cyc));
      check($sformatf("v%0d_cnt", i),      D'(match_cnt), D'(vecs[i].cnt));
      check($sformatf("v%0d_vld", i),      D'(first_vld), D'(vecs[i].vld));
      check($sformatf("v%0d_idx", i),      D'(first_idx), D'(vecs[i].idx));
      tick();
    end

    // start + tag_set_all together: start wins, tag comes from compare
    tag_set_all = 1'b1;
    run_pass(3'd1, {ALL1, ALL1, ONE << 3}, dcyc, wcyc);
    tag_set_all = 1'b0;
    check("start_vs_setall_tag", tag, ONE << 3);
    tick();

    // Second start during CNT is ignored: exactly one done
    pass_in = 3'd2; tag_cell_in = {ALL1, ALL1, ONE << 64}; start = 1'b1;
    tick();
    start = 1'b0; ndone = 0;
    for (int k = 0; k < 24; k++) begin
      start = (k == 4);
      pass_in = (k == 4) ? 3'd4 : 3'd2;
      tick();
      if (done) ndone++;
    end
    start = 1'b0;
    check("single_done", D'(ndone), D'(1));

    // Back-to-back: start the cycle after done; old results hold until new DONE
    run_pass(3'd1, {ALL1, ALL1, (ONE << 50) | (ONE << 51)}, dcyc, wcyc);
    tick();
    run_pass(3'd0, {ALL1, ALL1, ONE << 99}, dcyc, wcyc);
    check("b2b_done_cyc", D'(dcyc), D'(10));
    check("b2b_idx", D'(first_idx), D'(99));
    tick();

    // Reset in the middle of CNT (cycle 5)
    pass_in = 3'd1; tag_cell_in = {3{ALL1}}; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    assert_reset();
    check("rst_mid_busy", D'(busy), '0);
    ndone = 0;
    repeat (3) begin tick(); if (done) ndone++; end
    check("rst_no_done", D'(ndone), '0);
    rst_In = 1'b1;
    tick();

    // Randomised per-cycle stimulus
    for (int n = 0; n < 700; n++) begin
      start       = ($urandom_range(0, 5) == 0);
      pass_in     = 3'($urandom_range(0, 4));
      tag_set_all = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 4))
          0:       c[k] = {$urandom, $urandom, $urandom, $urandom};
          1:       c[k] = ~(ONE << $urandom_range(0, D - 1));
          2:       c[k] = ONE << $urandom_range(0, D - 1);
          3:       c[k] = '0;
          default: c[k] = ALL1;
        endcase
      end
      tag_cell_in = {c[2], c[1], c[0]};
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
